// File: rtl/wb_bcd_display_regs.sv
// wb_bcd_display_regs
// Wishbone classic slave that drives the two digit-byte inputs of the 4-digit
// 7-segment multiplexer (a0m = digits 3..2, a0l = digits 1..0).
//   BCD mode: a binary value written to BIN is converted to packed BCD by a
//             sequential double-dabble engine (one add-3/shift step per clock).
//   Raw mode: the 16-bit RAW register drives the digit nibbles directly.
// Register map (wb_adr_i[3:2]):
//   0 BIN    W starts a conversion, R returns the last accepted value
//   1 RAW    RW digit nibbles
//   2 CTRL   RW bit0 mode (0 = BCD, 1 = raw)
//   3 STATUS R bit0 busy, bit1 drop (sticky), bit2 ovf; write 1 to bit1/bit2 clears
// Optional build macro WB_BCD_OVF_SAT_EN: results above 9999 saturate to 9999
// and set STATUS.ovf. Without it the low four digits are kept (value mod 10000)
// and ovf always reads 0.

module wb_bcd_display_regs #(
  parameter int CONV_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [7:0]  a0m,
  output logic [7:0]  a0l,
  output logic        busy
);

  // Shift register holds five BCD digits above the binary operand.
  localparam int SR_W  = CONV_BITS + 20;
  localparam int CNT_W = (CONV_BITS > 1) ? $clog2(CONV_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADR_BIN    = 2'd0;
  localparam logic [1:0] ADR_RAW    = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
    logic [19:0] r;
    r = bcd;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Bus-side registers
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [CONV_BITS-1:0] bin_q, bin_d;
  logic [15:0]          raw_q, raw_d;
  logic                 mode_q, mode_d;
  logic                 drop_q, drop_d;

  // Conversion engine registers
  state_t               state_q;
  logic [SR_W-1:0]      sr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic [15:0]          result_q;

  // Bus decode
  logic       req;
  logic       wr;
  logic       rd;
  logic [1:0] adr;
  logic       start;
  logic       status_wr;
  logic       ovf_bit;

  // One double-dabble step
  logic [19:0]     bcd_adj;
  logic [SR_W-1:0] sr_step;

  // A new request is accepted only when no ack is outstanding, which makes
  // ack a single-cycle pulse and every access exactly two cycles long.
  assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = req & wb_we_i;
  assign rd        = req & ~wb_we_i;
  assign adr       = wb_adr_i[3:2];
  // busy_q stays high through LATCH, so a BIN write on the latch edge is
  // treated as a collision and dropped.
  assign start     = wr && (adr == ADR_BIN) && !busy_q;
  assign status_wr = wr && (adr == ADR_STATUS);

  assign bcd_adj = dd_adjust(sr_q[SR_W-1 -: 20]);
  assign sr_step = {bcd_adj[18:0], sr_q[CONV_BITS-1:0], 1'b0};

`ifdef WB_BCD_OVF_SAT_EN
  logic ovf_q;
  logic ovf_clr;
  assign ovf_clr = status_wr & wb_dat_i[2];
  assign ovf_bit = ovf_q;
`else
  assign ovf_bit = 1'b0;
`endif

  // Next-state for the bus registers: ack pulse, read data capture, register writes.
  always_comb begin
    ack_d  = req;
    dat_d  = dat_q;
    bin_d  = bin_q;
    raw_d  = raw_q;
    mode_d = mode_q;
    drop_d = drop_q;

    if (rd) begin
      case (adr)
        ADR_BIN:    dat_d = 32'(bin_q);
        ADR_RAW:    dat_d = {16'h0000, raw_q};
        ADR_CTRL:   dat_d = {31'h0, mode_q};
        ADR_STATUS: dat_d = {29'h0, ovf_bit, drop_q, busy_q};
        default:    dat_d = 32'h0;
      endcase
    end

    if (wr) begin
      case (adr)
        ADR_BIN: begin
          // A value arriving while a conversion is in flight is discarded.
          if (busy_q) begin
            drop_d = 1'b1;
          end else begin
            bin_d = wb_dat_i[CONV_BITS-1:0];
          end
        end
        ADR_RAW:    raw_d  = wb_dat_i[15:0];
        ADR_CTRL:   mode_d = wb_dat_i[0];
        ADR_STATUS: begin
          if (wb_dat_i[1]) begin
            drop_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
      bin_q  <= '0;
      raw_q  <= 16'h0;
      mode_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      bin_q  <= bin_d;
      raw_q  <= raw_d;
      mode_q <= mode_d;
      drop_q <= drop_d;
    end
  end

  // Conversion sequencer: load the operand, run CONV_BITS add-3/shift steps,
  // then latch the low four BCD digits into the result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      result_q <= 16'h0;
`ifdef WB_BCD_OVF_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
`ifdef WB_BCD_OVF_SAT_EN
      // Software clear; a saturating latch on the same edge wins below.
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sr_q    <= {20'h0, wb_dat_i[CONV_BITS-1:0]};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          sr_q  <= sr_step;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
`ifdef WB_BCD_OVF_SAT_EN
          // Ten-thousands digit set: the value does not fit in four digits.
          if (sr_q[SR_W-1 -: 4] != 4'h0) begin
            result_q <= 16'h9999;
            ovf_q    <= 1'b1;
          end else begin
            result_q <= sr_q[CONV_BITS+15:CONV_BITS];
          end
`else
          result_q <= sr_q[CONV_BITS+15:CONV_BITS];
`endif
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Display select is purely combinational from registers, so a mode change
  // shows up the cycle after its ack.
  assign a0m = mode_q ? raw_q[15:8] : result_q[15:8];
  assign a0l = mode_q ? raw_q[7:0]  : result_q[7:0];

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign busy     = busy_q;

  // Inputs and bits that carry no function in this block.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i, bcd_adj[19]};

endmodule

// File: tb/tb_wb_bcd_display_regs.sv
// Scoreboard bench for wb_bcd_display_regs: each bus access pushes its expected
// response, a monitor pops and compares on every ack, and a second monitor
// checks the length of each busy pulse against expected lengths.

module tb_wb_bcd_display_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  a0m, a0l;
  logic        busy;

  always #5 clk = ~clk;

  wb_bcd_display_regs #(.CONV_BITS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .a0m      (a0m),
    .a0l      (a0l),
    .busy     (busy)
  );

  typedef struct {
    string       name;
    bit          chk_dat;
    logic [31:0] dat;
    bit          chk_disp;
    logic [7:0]  m;
    logic [7:0]  l;
    bit          chk_busy;
    logic        bsy;
  } exp_t;

  localparam logic [1:0] R_BIN = 2'd0, R_RAW = 2'd1, R_CTRL = 2'd2, R_STATUS = 2'd3;

  exp_t exp_q[$];
  int   busy_len_q[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string n, input bit cd, input logic [31:0] d,
                              input bit cp, input logic [7:0] m, input logic [7:0] l,
                              input bit cb, input logic b);
    exp_t e;
    e.name = n; e.chk_dat = cd; e.dat = d; e.chk_disp = cp; e.m = m; e.l = l;
    e.chk_busy = cb; e.bsy = b;
    return e;
  endfunction

  // Response monitor: every ack consumes one expected record.
  initial begin : resp_mon
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (wb_ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard, required none");
        end else begin
          e = exp_q.pop_front();
          if (e.chk_dat)  check({e.name, "_dat"}, wb_dat_o, e.dat);
          if (e.chk_disp) begin
            check({e.name, "_a0m"}, 32'(a0m), 32'(e.m));
            check({e.name, "_a0l"}, 32'(a0l), 32'(e.l));
          end
          if (e.chk_busy) check({e.name, "_busy"}, 32'(busy), 32'(e.bsy));
        end
      end
    end
  end

  // Busy-pulse monitor: length in cycles of each busy assertion.
  initial begin : busy_mon
    int run;
    int req;
    run = 0;
    forever begin
      @(posedge clk); #1;
      if (busy === 1'b1) begin
        run++;
      end else if (run != 0) begin
        if (busy_len_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL busy_len: got unexpected busy pulse of %0d cycles, required none", run);
        end else begin
          req = busy_len_q.pop_front();
          check("busy_len", 32'(run), 32'(req));
        end
        run = 0;
      end
    end
  end

  task automatic wb(input bit we, input logic [1:0] r, input logic [31:0] d, input exp_t e);
    int n;
    exp_q.push_back(e);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {28'h0, r, 2'b00}; wb_dat_i = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (wb_ack_o !== 1'b1 && n < 20);
    if (wb_ack_o !== 1'b1) begin
      nvec++; nfail++;
      $display("FAIL ack_timeout %s: got no ack in %0d cycles, required ack", e.name, n);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy !== 1'b0 && n < 100);
    if (busy !== 1'b0) begin
      nvec++; nfail++;
      $display("FAIL idle_timeout: got busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    wb(0, R_STATUS, 0, mk("rst_status", 1, 32'h0, 1, 8'h00, 8'h00, 1, 0));
    wb(0, R_BIN,    0, mk("rst_bin",    1, 32'h0, 0, 0, 0, 0, 0));
    wb(0, R_RAW,    0, mk("rst_raw",    1, 32'h0, 0, 0, 0, 0, 0));
    wb(0, R_CTRL,   0, mk("rst_ctrl",   1, 32'h0, 0, 0, 0, 0, 0));

    // 1234
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'h04D2, mk("bin1234_wr", 0, 0, 1, 8'h00, 8'h00, 1, 1));
    wb(0, R_STATUS, 0, mk("busy_status", 1, 32'h1, 1, 8'h00, 8'h00, 1, 1));
    wait_idle();
    wb(0, R_STATUS, 0, mk("res1234", 1, 32'h0, 1, 8'h12, 8'h34, 1, 0));
    wb(0, R_BIN, 0, mk("bin1234_rd", 1, 32'h000004D2, 0, 0, 0, 0, 0));

    // 9999 then 0
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'd9999, mk("bin9999_wr", 0, 0, 0, 0, 0, 1, 1));
    wait_idle();
    wb(0, R_STATUS, 0, mk("res9999", 1, 32'h0, 1, 8'h99, 8'h99, 1, 0));
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'd0, mk("bin0_wr", 0, 0, 0, 0, 0, 1, 1));
    wait_idle();
    wb(0, R_STATUS, 0, mk("res0", 1, 32'h0, 1, 8'h00, 8'h00, 1, 0));

    // 65535: overflow handling
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'hFFFF, mk("binffff_wr", 0, 0, 0, 0, 0, 1, 1));
    wait_idle();
`ifdef WB_BCD_OVF_SAT_EN
    wb(0, R_STATUS, 0, mk("resffff", 1, 32'h4, 1, 8'h99, 8'h99, 1, 0));
`else
    wb(0, R_STATUS, 0, mk("resffff", 1, 32'h0, 1, 8'h55, 8'h35, 1, 0));
`endif
    wb(1, R_STATUS, 32'h4, mk("ovf_clr_wr", 0, 0, 0, 0, 0, 0, 0));
    wb(0, R_STATUS, 0, mk("ovf_clr_rd", 1, 32'h0, 0, 0, 0, 1, 0));

    // 42, then 77 dropped on the 5th busy cycle
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'd42, mk("bin42_wr", 0, 0, 0, 0, 0, 1, 1));
    repeat (3) @(posedge clk);
    wb(1, R_BIN, 32'd77, mk("bin77_drop", 0, 0, 0, 0, 0, 1, 1));
    wait_idle();
    wb(0, R_STATUS, 0, mk("res42_drop", 1, 32'h2, 1, 8'h00, 8'h42, 1, 0));
    wb(0, R_BIN, 0, mk("bin42_rd", 1, 32'd42, 0, 0, 0, 0, 0));
    wb(1, R_STATUS, 32'h2, mk("drop_clr_wr", 0, 0, 0, 0, 0, 0, 0));
    wb(0, R_STATUS, 0, mk("drop_clr_rd", 1, 32'h0, 1, 8'h00, 8'h42, 1, 0));

    // Write landing on the latch edge is dropped
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'd123, mk("bin123_wr", 0, 0, 0, 0, 0, 1, 1));
    repeat (16) @(posedge clk);
    wb(1, R_BIN, 32'd456, mk("bin_latch_edge", 0, 0, 1, 8'h01, 8'h23, 1, 0));
    wb(0, R_STATUS, 0, mk("latch_drop", 1, 32'h2, 0, 0, 0, 0, 0));
    wb(0, R_BIN, 0, mk("bin123_rd", 1, 32'd123, 0, 0, 0, 0, 0));
    wb(1, R_STATUS, 32'h2, mk("drop_clr2_wr", 0, 0, 0, 0, 0, 0, 0));

    // Raw mode
    wb(1, R_RAW,  32'hBEEF, mk("raw_wr",  0, 0, 1, 8'h01, 8'h23, 0, 0));
    wb(1, R_CTRL, 32'h1,    mk("mode1",   0, 0, 1, 8'hBE, 8'hEF, 0, 0));
    wb(0, R_RAW,  0,        mk("raw_rd",  1, 32'hBEEF, 0, 0, 0, 0, 0));
    wb(0, R_CTRL, 0,        mk("ctrl_rd", 1, 32'h1, 0, 0, 0, 0, 0));
    wb(1, R_CTRL, 32'h0,    mk("mode0",   0, 0, 1, 8'h01, 8'h23, 0, 0));
    wb(1, R_CTRL, 32'h1,    mk("mode1b",  0, 0, 1, 8'hBE, 8'hEF, 0, 0));
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'h10, mk("bin16_raw", 0, 0, 1, 8'hBE, 8'hEF, 1, 1));
    wait_idle();
    wb(0, R_STATUS, 0, mk("res16_hidden", 1, 32'h0, 1, 8'hBE, 8'hEF, 1, 0));
    wb(1, R_CTRL, 32'h0, mk("mode0b", 0, 0, 1, 8'h00, 8'h16, 0, 0));

    // Reset mid-conversion
    busy_len_q.push_back(8);
    wb(1, R_BIN, 32'h04D2, mk("bin1234_abort", 0, 0, 0, 0, 0, 1, 1));
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wb(0, R_STATUS, 0, mk("abort_status", 1, 32'h0, 1, 8'h00, 8'h00, 1, 0));
    wb(0, R_BIN,    0, mk("abort_bin",    1, 32'h0, 0, 0, 0, 0, 0));
    wb(0, R_RAW,    0, mk("abort_raw",    1, 32'h0, 0, 0, 0, 0, 0));
    busy_len_q.push_back(17);
    wb(1, R_BIN, 32'd56, mk("bin56_wr", 0, 0, 1, 8'h00, 8'h00, 1, 1));
    wait_idle();
    wb(0, R_STATUS, 0, mk("res56", 1, 32'h0, 1, 8'h00, 8'h56, 1, 0));

    repeat (5) @(posedge clk);
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("busy_q_left", 32'(busy_len_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/wb_bcd_display_regs.md
Name: wb_bcd_display_regs

Overview:
Wishbone classic slave feeding the 4-digit 7-segment multiplexer's two digit-byte inputs (a0m = digits 3..2, a0l = digits 1..0).
- BCD mode: a binary value written by the CPU is converted to 4 packed BCD digits with a sequential double-dabble engine.
- Raw mode: a software-written 16-bit nibble pattern drives the digits directly.
- Sits between the LM32 Wishbone bus and the display multiplexer.

Parameters:
- CONV_BITS, 16, width of the binary input and the number of double-dabble iterations.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address; only [3:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects, ignored (full-word access only)
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- a0m  out  8  digits 3..2 to display multiplexer
- a0l  out  8  digits 1..0 to display multiplexer
- busy  out  1  conversion in progress

Behaviour:
- Reset value of every output and register is 0: wb_ack_o, wb_dat_o, a0m, a0l, busy, BIN, RAW, CTRL, STATUS flags, result register. FSM goes to IDLE.
- Bus handshake:
  - wb_ack_o pulses for one cycle on the edge where cyc&stb=1 and ack=0, so the minimum transaction is 2 cycles.
  - A write takes effect on the ack edge.
  - wb_dat_o is registered on the ack edge. Unused bits read 0.
- Register map (adr[3:2]):
  - 0 BIN: W [15:0] starts a conversion. R returns the last accepted value.
  - 1 RAW: RW [15:0] direct digit nibbles.
  - 2 CTRL: RW bit0 mode (0 = BCD, 1 = raw).
  - 3 STATUS: R bit0 busy, bit1 drop (sticky), bit2 ovf. Writing 1 to bit1 or bit2 clears that bit. Other writes are ignored.
- FSM states: IDLE, CONV, LATCH.
  - IDLE: a BIN write at edge E0 loads shift reg = {20'b0, value}, sets counter = 0 and busy = 1, and goes to CONV.
  - CONV: each edge, every 4-bit BCD nibble >= 5 gets +3, then the 36-bit register shifts left 1 and the counter increments. After CONV_BITS iterations (edges E1..E16) go to LATCH.
  - LATCH: at E17, the result register gets the low 4 BCD digits, busy = 0, state goes to IDLE.
  - Result is visible on a0m/a0l after E17, i.e. 17 cycles after the write's ack edge.
- BCD range: 5 BCD digits (20 bits) are held internally. Digit 4 is nonzero when value > 9999. Truncation or saturation is defined under Optional Feature.
- Output select: mode=1 gives a0m = RAW[15:8], a0l = RAW[7:0]. mode=0 gives the result register. The mux is combinational from registers, so a mode change is visible the cycle after its ack.
- BIN write while busy: ignored, value is not captured, the conversion in flight is unaffected, drop is set to 1, and the write is still acked.
- BIN write on the same edge as LATCH: treated as busy, so it is dropped.
- Reset mid-conversion: aborts immediately, all state returns to reset values, and a0m/a0l read 0.
- Converting in raw mode is allowed. The result register updates but is not shown until mode=0.

Optional Feature:
- Macro: WB_BCD_OVF_SAT_EN.
- Defined: at LATCH, if BCD digit 4 != 0, the result is forced to 0x9999 and STATUS.ovf is set to 1.
- Undefined: the result is the low 4 digits (value mod 10000), and STATUS.ovf stays 0 (no ovf bit logic is generated).

Test Plan:
- Reset, then write BIN=0x04D2 (1234) -> busy=1 for 17 cycles, then a0m=0x12, a0l=0x34, busy=0; read BIN returns 0x000004D2.
- Write BIN=9999, then BIN=0 -> 0x99/0x99, then 0x00/0x00 each after 17 cycles; ovf stays 0.
- Write BIN=0xFFFF (65535) -> with WB_BCD_OVF_SAT_EN: a0m=0x99, a0l=0x99, STATUS=0x4. Without it: a0m=0x55, a0l=0x35, STATUS=0x0.
- Write BIN=42, then BIN=77 at the 5th cycle of busy -> a0m=0x00, a0l=0x42; STATUS.drop=1; write STATUS=0x2 -> drop=0.
- Write RAW=0xBEEF, CTRL=1 -> a0m=0xBE, a0l=0xEF; CTRL=0 -> the last BCD result is shown again.
- Write BIN=1234, assert reset at the 8th CONV cycle for 1 cycle -> a0m=a0l=0, busy=0, state IDLE; a new BIN=56 write completes to 0x00/0x56.
